prewish_multiblinky: RTL and testbench
======================================

// Module: prewish_multiblinky
// PURPOSE
//  Parametrised successor to the single-LED prewish blinky: NUM_CH independent LED channels, each
//  playing a MASK_W-bit pattern at a shared prescaled mask-clock rate, in loop, one-shot or static mode.
//  Loaded via a strobe/data/channel port from the controller; drives the icestick LEDs.
// PARAMETERS
//  NUM_CH        4   number of LED channels (>=1)
//  MASK_W        8   pattern bits per channel (>=2)
//  MASK_CLK_BITS 9   prescaler width; one mask tick every 2**MASK_CLK_BITS clocks
//  CH_W          $clog2(NUM_CH) (min 1) channel-select width, derived
// PORTS
//  i_clk    in   1       system clock
//  i_rst_n  in   1       async reset, active low
//  STB_I    in   1       load strobe (level; edge-detected internally)
//  CH_I     in   CH_W    target channel, sampled with STB_I
//  DAT_I    in   MASK_W  pattern, sampled with STB_I
//  MODE_I   in   2       00 OFF, 01 LOOP, 10 ONESHOT, 11 STATIC
//  ACK_O    out  1       one-cycle pulse: load accepted
//  o_led    out  NUM_CH  per-channel LED, active high
//  o_busy   out  NUM_CH  channel is in RUN state
// BEHAVIOUR
//  - Reset: prescaler=0, all masks=0, all channels IDLE, o_led=0, o_busy=0, ACK_O=0, stb_q=0.
//  - Load: accepted on cycle where STB_I=1 and stb_q=0 (rising edge); long strobe loads once.
//    ACK_O=1 the cycle after acceptance. CH_I>=NUM_CH: ACK_O still pulses, no channel changes.
//  - Prescaler: free-running MASK_CLK_BITS counter, wraps; tick=1 when count==all-ones.
//  - Channel states: IDLE, RUN, HOLD.
//    load OFF -> IDLE, led=0. load STATIC -> HOLD, led=|DAT_I (constant). load LOOP/ONESHOT -> RUN,
//    shreg=DAT_I, bitcnt=0, led unchanged until first tick.
//    RUN tick: led=shreg[MASK_W-1]; LOOP: shreg rotates left, bitcnt ignored;
//    ONESHOT: shreg shifts left (0 fill), bitcnt++; tick with bitcnt==MASK_W -> IDLE, led=0.
//    So ONESHOT shows MASK_W bits, each one tick long, then dark.
//  - Latency: load->first LED change = next tick (<=2**MASK_CLK_BITS clocks); all channels
//    tick on the same cycle (phase-locked).
//  - Load on a running channel: restarts immediately (shreg, bitcnt, mode replaced).
//  - Load and tick same cycle, same channel: load wins, tick dropped for that channel;
//    other channels tick normally.
//  - o_busy = (state==RUN). All outputs registered. Reset mid-pattern returns everything to reset
//    values at once; prescaler restarts from 0.
//  - bitcnt width $clog2(MASK_W+1); no arithmetic overflow possible.
// STRUCTURE
//  - Package prewish_pkg: MODE_OFF/LOOP/ONESHOT/STATIC localparams, channel-state encodings.
//  - Top: strobe edge detect, ACK, prescaler, channel decode; generate loop of NUM_CH
//    prewish_blink_chan (inputs: clk, rst_n, tick, load, mode, data; outputs: led, busy).
// TESTING (bench: NUM_CH=4, MASK_W=8, MASK_CLK_BITS=2 -> tick every 4 clocks)
//  1 reset mid-run: load ch0 LOOP 8'hAA, pull i_rst_n low async -> o_led=0, o_busy=0 immediately.
//  2 LOOP ch1 8'b1100_0000 -> o_led[1] sequence over ticks 1,1,0,0,0,0,0,0,1,1..., o_busy[1]=1.
//  3 ONESHOT ch2 8'b1010_0001 -> led 1,0,1,0,0,0,0,1 then 0 on 9th tick; o_busy[2] falls there.
//  4 STB_I held 20 clocks, ch3 STATIC 8'h01 -> exactly one ACK_O pulse, o_led[3]=1 steady;
//    then STATIC 8'h00 -> o_led[3]=0.
//  5 load ch0 timed to the tick cycle while ch1 LOOPs -> ch0 restarts from bit 7 at next tick,
//    ch1 pattern undisturbed.
//  6 CH_I=3 reload mid-ONESHOT with LOOP 8'hF0 -> restart, no return to IDLE; CH_W-range check
//    with NUM_CH=3, CH_I=3 -> ACK_O pulses, no output change.

Source files
------------

// File: rtl/prewish_pkg.sv
// Shared mode codes and channel-state encodings for the multi-channel LED pattern player.
package prewish_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_LOOP    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_STATIC  = 2'b11;

    typedef enum logic [1:0] {
        CH_IDLE = 2'b00,
        CH_RUN  = 2'b01,
        CH_HOLD = 2'b10
    } chan_state_t;

endpackage

// File: rtl/prewish_blink_chan.sv
// One LED channel: plays a MASK_W-bit pattern one bit per tick (loop or one-shot),
// or holds a static level. A load always takes priority over a tick.
module prewish_blink_chan
    import prewish_pkg::*;
#(
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              load,
    input  logic [1:0]        mode,
    input  logic [MASK_W-1:0] data,
    output logic              led,
    output logic              busy
);

    localparam int CNT_W = $clog2(MASK_W + 1);

    chan_state_t       state, state_nxt;
    logic [MASK_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  bitcnt, bitcnt_nxt;
    logic              oneshot, oneshot_nxt;
    logic              led_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CH_IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            oneshot <= 1'b0;
            led     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bitcnt  <= bitcnt_nxt;
            oneshot <= oneshot_nxt;
            led     <= led_nxt;
            busy    <= (state_nxt == CH_RUN);
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bitcnt_nxt  = bitcnt;
        oneshot_nxt = oneshot;
        led_nxt     = led;
        if (load) begin
            oneshot_nxt = (mode == MODE_ONESHOT);
            case (mode)
                MODE_OFF: begin
                    state_nxt = CH_IDLE;
                    led_nxt   = 1'b0;
                end
                MODE_STATIC: begin
                    state_nxt = CH_HOLD;
                    led_nxt   = |data;
                end
                default: begin
                    // LED keeps its old level until the first tick of the new pattern
                    state_nxt  = CH_RUN;
                    shreg_nxt  = data;
                    bitcnt_nxt = '0;
                end
            endcase
        end else if (tick && state == CH_RUN) begin
            if (!oneshot) begin
                led_nxt   = shreg[MASK_W-1];
                shreg_nxt = {shreg[MASK_W-2:0], shreg[MASK_W-1]};
            end else if (bitcnt == CNT_W'(MASK_W)) begin
                state_nxt = CH_IDLE;
                led_nxt   = 1'b0;
            end else begin
                led_nxt    = shreg[MASK_W-1];
                shreg_nxt  = {shreg[MASK_W-2:0], 1'b0};
                bitcnt_nxt = bitcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/prewish_multiblinky.sv
// NUM_CH phase-locked LED pattern channels sharing one prescaled tick, loaded through
// an edge-detected strobe/channel/data port with a one-cycle acknowledge.
module prewish_multiblinky
    import prewish_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int MASK_W        = 8,
    parameter int MASK_CLK_BITS = 9,
    parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              STB_I,
    input  logic [CH_W-1:0]   CH_I,
    input  logic [MASK_W-1:0] DAT_I,
    input  logic [1:0]        MODE_I,
    output logic              ACK_O,
    output logic [NUM_CH-1:0] o_led,
    output logic [NUM_CH-1:0] o_busy
);

    logic                     stb_q;
    logic                     accept;
    logic                     tick;
    logic [MASK_CLK_BITS-1:0] presc;
    logic [NUM_CH-1:0]        load;

    assign accept = STB_I & ~stb_q;
    assign tick   = &presc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stb_q <= 1'b0;
            ACK_O <= 1'b0;
            presc <= '0;
        end else begin
            stb_q <= STB_I;
            ACK_O <= accept;
            presc <= presc + MASK_CLK_BITS'(1);
        end
    end

    // Out-of-range channel numbers match no channel but are still acknowledged
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign load[i] = accept && (CH_I == CH_W'(i));

        prewish_blink_chan #(
            .MASK_W (MASK_W)
        ) u_chan (
            .clk   (i_clk),
            .rst_n (i_rst_n),
            .tick  (tick),
            .load  (load[i]),
            .mode  (MODE_I),
            .data  (DAT_I),
            .led   (o_led[i]),
            .busy  (o_busy[i])
        );
    end

endmodule

// File: tb/tb_prewish_multiblinky.sv
// Scoreboard bench for prewish_multiblinky: 4-channel instance plus a 3-channel instance
// for the out-of-range channel-select case; mask tick every 4 clocks.
module tb_prewish_multiblinky;
    import prewish_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stb = 1'b0;
    logic [1:0] ch = '0;
    logic [7:0] dat = '0;
    logic [1:0] mode = '0;
    logic       ack;
    logic [3:0] led;
    logic [3:0] busy;

    logic       stb3 = 1'b0;
    logic [1:0] ch3 = '0;
    logic [7:0] dat3 = '0;
    logic [1:0] mode3 = '0;
    logic       ack3;
    logic [2:0] led3;
    logic [2:0] busy3;

    int checks = 0;
    int fails = 0;
    int cyc;

    always #5 clk = ~clk;

    // Free-running cycle count since reset; an edge was a mask tick when cyc%4 becomes 0
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    prewish_multiblinky #(
        .NUM_CH(4), .MASK_W(8), .MASK_CLK_BITS(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .STB_I(stb), .CH_I(ch), .DAT_I(dat),
        .MODE_I(mode), .ACK_O(ack), .o_led(led), .o_busy(busy)
    );

    prewish_multiblinky #(
        .NUM_CH(3), .MASK_W(8), .MASK_CLK_BITS(2)
    ) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .STB_I(stb3), .CH_I(ch3), .DAT_I(dat3),
        .MODE_I(mode3), .ACK_O(ack3), .o_led(led3), .o_busy(busy3)
    );

    task automatic align_tick();
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (cyc % 4 == 0) break;
        end
    endtask

    // Load right after a tick so the load edge never coincides with a tick
    task automatic do_load(input int c, input logic [1:0] m, input logic [7:0] d);
        logic [7:0] cv;
        cv = 8'(c);
        align_tick();
        stb = 1'b1; ch = cv[1:0]; mode = m; dat = d;
        @(posedge clk); #1;
        stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (led !== 4'b0)  begin fails++; $display("FAIL reset_led: got %b expected %b", led, 4'b0); end
        checks++; if (busy !== 4'b0) begin fails++; $display("FAIL reset_busy: got %b expected %b", busy, 4'b0); end
        checks++; if (ack !== 1'b0)  begin fails++; $display("FAIL reset_ack: got %b expected %b", ack, 1'b0); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        do_load(0, MODE_LOOP, 8'hAA);
        align_tick();
        checks++; if (led[0] !== 1'b1)  begin fails++; $display("FAIL midrun_led_before: got %b expected %b", led[0], 1'b1); end
        checks++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL midrun_busy_before: got %b expected %b", busy[0], 1'b1); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (led !== 4'b0)  begin fails++; $display("FAIL midrun_led_async: got %b expected %b", led, 4'b0); end
        checks++; if (busy !== 4'b0) begin fails++; $display("FAIL midrun_busy_async: got %b expected %b", busy, 4'b0); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_loop();
        logic [7:0] pat = 8'b1100_0000;
        logic       q[$];
        logic       e;
        for (int k = 0; k < 10; k++) q.push_back(pat[7 - (k % 8)]);
        do_load(1, MODE_LOOP, pat);
        checks++; if (led[1] !== 1'b0) begin fails++; $display("FAIL loop_led_pre_tick: got %b expected %b", led[1], 1'b0); end
        for (int t = 0; t < 10; t++) begin
            align_tick();
            e = q.pop_front();
            checks++; if (led[1] !== e)     begin fails++; $display("FAIL loop_led t%0d: got %b expected %b", t, led[1], e); end
            checks++; if (busy[1] !== 1'b1) begin fails++; $display("FAIL loop_busy t%0d: got %b expected %b", t, busy[1], 1'b1); end
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] pat = 8'b1010_0001;
        logic       ql[$];
        logic       qb[$];
        logic       el, eb;
        for (int k = 0; k < 8; k++) begin ql.push_back(pat[7 - k]); qb.push_back(1'b1); end
        ql.push_back(1'b0); qb.push_back(1'b0);
        do_load(2, MODE_ONESHOT, pat);
        for (int t = 0; t < 9; t++) begin
            align_tick();
            el = ql.pop_front();
            eb = qb.pop_front();
            checks++; if (led[2] !== el)  begin fails++; $display("FAIL oneshot_led t%0d: got %b expected %b", t, led[2], el); end
            checks++; if (busy[2] !== eb) begin fails++; $display("FAIL oneshot_busy t%0d: got %b expected %b", t, busy[2], eb); end
        end
    endtask

    task automatic test_static_hold();
        align_tick();
        stb = 1'b1; ch = 2'd3; mode = MODE_STATIC; dat = 8'h01;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++; if (ack !== (i == 0)) begin fails++; $display("FAIL static_ack c%0d: got %b expected %b", i, ack, (i == 0)); end
            checks++; if (led[3] !== 1'b1)  begin fails++; $display("FAIL static_led c%0d: got %b expected %b", i, led[3], 1'b1); end
        end
        stb = 1'b0;
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0)     begin fails++; $display("FAIL static_ack_release: got %b expected %b", ack, 1'b0); end
        checks++; if (busy[3] !== 1'b0) begin fails++; $display("FAIL static_busy: got %b expected %b", busy[3], 1'b0); end
        do_load(3, MODE_STATIC, 8'h00);
        checks++; if (led[3] !== 1'b0)  begin fails++; $display("FAIL static_zero_led: got %b expected %b", led[3], 1'b0); end
    endtask

    task automatic test_load_on_tick();
        logic [7:0] p1 = 8'hA5;
        logic [7:0] p0a = 8'hC0;
        logic [7:0] p0b = 8'h3C;
        logic       q0[$];
        logic       q1[$];
        logic       e0, e1;
        for (int k = 1; k < 12; k++) q1.push_back(p1[7 - (k % 8)]);
        q0.push_back(p0a[7]); q0.push_back(p0a[6]);
        q0.push_back(p0a[6]);
        for (int k = 0; k < 8; k++) q0.push_back(p0b[7 - k]);
        do_load(1, MODE_LOOP, p1);
        do_load(0, MODE_LOOP, p0a);
        checks++; if (led[1] !== p1[7]) begin fails++; $display("FAIL ontick_ch1_first: got %b expected %b", led[1], p1[7]); end
        for (int t = 0; t < 11; t++) begin
            if (t == 2) begin
                repeat (3) begin @(posedge clk); #1; end
                stb = 1'b1; ch = 2'd0; mode = MODE_LOOP; dat = p0b;
                @(posedge clk); #1;
                stb = 1'b0;
            end else begin
                align_tick();
            end
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++; if (led[0] !== e0) begin fails++; $display("FAIL ontick_ch0 t%0d: got %b expected %b", t, led[0], e0); end
            checks++; if (led[1] !== e1) begin fails++; $display("FAIL ontick_ch1 t%0d: got %b expected %b", t, led[1], e1); end
        end
    endtask

    task automatic test_reload_oneshot();
        logic [7:0] pa = 8'hA1;
        logic [7:0] pb = 8'hF0;
        logic       q[$];
        logic       e;
        for (int k = 0; k < 3; k++) q.push_back(pa[7 - k]);
        for (int k = 0; k < 9; k++) q.push_back(pb[7 - (k % 8)]);
        do_load(3, MODE_ONESHOT, pa);
        for (int t = 0; t < 3; t++) begin
            align_tick();
            e = q.pop_front();
            checks++; if (led[3] !== e) begin fails++; $display("FAIL reload_os_led t%0d: got %b expected %b", t, led[3], e); end
        end
        do_load(3, MODE_LOOP, pb);
        checks++; if (busy[3] !== 1'b1) begin fails++; $display("FAIL reload_busy_after_load: got %b expected %b", busy[3], 1'b1); end
        for (int t = 0; t < 9; t++) begin
            align_tick();
            e = q.pop_front();
            checks++; if (led[3] !== e)     begin fails++; $display("FAIL reload_loop_led t%0d: got %b expected %b", t, led[3], e); end
            checks++; if (busy[3] !== 1'b1) begin fails++; $display("FAIL reload_loop_busy t%0d: got %b expected %b", t, busy[3], 1'b1); end
        end
    endtask

    task automatic test_ch_range();
        align_tick();
        stb3 = 1'b1; ch3 = 2'd0; mode3 = MODE_STATIC; dat3 = 8'h01;
        @(posedge clk); #1;
        stb3 = 1'b0;
        checks++; if (ack3 !== 1'b1)    begin fails++; $display("FAIL range_ack_valid: got %b expected %b", ack3, 1'b1); end
        checks++; if (led3 !== 3'b001)  begin fails++; $display("FAIL range_led_valid: got %b expected %b", led3, 3'b001); end
        @(posedge clk); #1;
        checks++; if (ack3 !== 1'b0)    begin fails++; $display("FAIL range_ack_clear: got %b expected %b", ack3, 1'b0); end
        stb3 = 1'b1; ch3 = 2'd3; mode3 = MODE_LOOP; dat3 = 8'hF0;
        @(posedge clk); #1;
        stb3 = 1'b0;
        checks++; if (ack3 !== 1'b1)    begin fails++; $display("FAIL range_ack_oob: got %b expected %b", ack3, 1'b1); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++; if (led3 !== 3'b001) begin fails++; $display("FAIL range_led c%0d: got %b expected %b", i, led3, 3'b001); end
            checks++; if (busy3 !== 3'b000) begin fails++; $display("FAIL range_busy c%0d: got %b expected %b", i, busy3, 3'b000); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_reset_mid_run();
        test_loop();
        test_oneshot();
        test_static_hold();
        test_load_on_tick();
        test_reload_oneshot();
        test_ch_range();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
